// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and ALU-issue bundle of the arithmetic reservation station.
// The producer side (dispatch, ALU/LSB broadcasts, ALU consumer) uses master; the station uses slave.
interface reservation_station_if #(
  parameter int ROB_ID_WIDTH = 3,
  parameter int OP_WIDTH     = 7,
  parameter int VAL_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
);
  localparam int TAG_W = ROB_ID_WIDTH + 1;

  logic                  issue_valid;
  logic [OP_WIDTH-1:0]   issue_type;
  logic [VAL_WIDTH-1:0]  issue_v1;
  logic [VAL_WIDTH-1:0]  issue_v2;
  logic                  issue_q1_busy;
  logic                  issue_q2_busy;
  logic [TAG_W-1:0]      issue_q1;
  logic [TAG_W-1:0]      issue_q2;
  logic [TAG_W-1:0]      issue_entry;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic                  rs_full;

  logic                  alu_ready;
  logic [TAG_W-1:0]      alu_entry;
  logic [VAL_WIDTH-1:0]  alu_val;
  logic                  lsb_ready;
  logic [TAG_W-1:0]      lsb_entry;
  logic [VAL_WIDTH-1:0]  lsb_val;

  // "type" is a reserved word, so the issued op-type travels as op_type.
  logic                  execute;
  logic [OP_WIDTH-1:0]   op_type;
  logic [VAL_WIDTH-1:0]  val1;
  logic [VAL_WIDTH-1:0]  val2;
  logic [TAG_W-1:0]      entry;
  logic [ADDR_WIDTH-1:0] nowPC;

  modport master (
    output issue_valid, issue_type, issue_v1, issue_v2, issue_q1_busy, issue_q2_busy,
           issue_q1, issue_q2, issue_entry, issue_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    input  rs_full, execute, op_type, val1, val2, entry, nowPC
  );

  modport slave (
    input  issue_valid, issue_type, issue_v1, issue_v2, issue_q1_busy, issue_q2_busy,
           issue_q1, issue_q2, issue_entry, issue_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    output rs_full, execute, op_type, val1, val2, entry, nowPC
  );
endinterface

// File: rtl/reservation_station.sv
// Integer-ALU reservation station: holds renamed instructions, wakes operands from the
// ALU/LSB broadcasts and issues the lowest-index ready slot to the ALU each cycle.
module reservation_station #(
  parameter int RS_SIZE      = 8,
  parameter int ROB_ID_WIDTH = 3,
  parameter int OP_WIDTH     = 7,
  parameter int VAL_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush,
  reservation_station_if.slave bus
);
  localparam int TAG_W = ROB_ID_WIDTH + 1;
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]    busy;
  logic [RS_SIZE-1:0]    q1_busy;
  logic [RS_SIZE-1:0]    q2_busy;
  logic [OP_WIDTH-1:0]   op_q  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  v1_q  [RS_SIZE];
  logic [VAL_WIDTH-1:0]  v2_q  [RS_SIZE];
  logic [TAG_W-1:0]      q1_q  [RS_SIZE];
  logic [TAG_W-1:0]      q2_q  [RS_SIZE];
  logic [TAG_W-1:0]      ent_q [RS_SIZE];
  logic [ADDR_WIDTH-1:0] pc_q  [RS_SIZE];

  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic                  rdy_found;
  logic [IDX_W-1:0]      rdy_idx;
  logic [VAL_WIDTH-1:0]  ins_v1;
  logic [VAL_WIDTH-1:0]  ins_v2;
  logic                  ins_q1_busy;
  logic                  ins_q2_busy;

  assign bus.rs_full = &busy;

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && !q1_busy[i] && !q2_busy[i]) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  // Operands arriving with a tag that is broadcast in the same cycle are stored ready.
  always_comb begin
    ins_v1      = bus.issue_v1;
    ins_q1_busy = bus.issue_q1_busy;
    ins_v2      = bus.issue_v2;
    ins_q2_busy = bus.issue_q2_busy;
    if (bus.issue_q1_busy) begin
      if (bus.alu_ready && bus.issue_q1 == bus.alu_entry) begin
        ins_v1      = bus.alu_val;
        ins_q1_busy = 1'b0;
      end else if (bus.lsb_ready && bus.issue_q1 == bus.lsb_entry) begin
        ins_v1      = bus.lsb_val;
        ins_q1_busy = 1'b0;
      end
    end
    if (bus.issue_q2_busy) begin
      if (bus.alu_ready && bus.issue_q2 == bus.alu_entry) begin
        ins_v2      = bus.alu_val;
        ins_q2_busy = 1'b0;
      end else if (bus.lsb_ready && bus.issue_q2 == bus.lsb_entry) begin
        ins_v2      = bus.lsb_val;
        ins_q2_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      q1_busy     <= '0;
      q2_busy     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      bus.execute <= 1'b0;
      bus.op_type <= '0;
      bus.val1    <= '0;
      bus.val2    <= '0;
      bus.entry   <= '0;
      bus.nowPC   <= '0;
    end else if (flush) begin
      busy        <= '0;
      bus.execute <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && q1_busy[i]) begin
          if (bus.alu_ready && q1_q[i] == bus.alu_entry) begin
            v1_q[i]    <= bus.alu_val;
            q1_busy[i] <= 1'b0;
          end else if (bus.lsb_ready && q1_q[i] == bus.lsb_entry) begin
            v1_q[i]    <= bus.lsb_val;
            q1_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && q2_busy[i]) begin
          if (bus.alu_ready && q2_q[i] == bus.alu_entry) begin
            v2_q[i]    <= bus.alu_val;
            q2_busy[i] <= 1'b0;
          end else if (bus.lsb_ready && q2_q[i] == bus.lsb_entry) begin
            v2_q[i]    <= bus.lsb_val;
            q2_busy[i] <= 1'b0;
          end
        end
      end

      // The free slot is never the dispatched slot, so both writes can coexist.
      if (bus.issue_valid && free_found) begin
        busy[free_idx]    <= 1'b1;
        op_q[free_idx]    <= bus.issue_type;
        v1_q[free_idx]    <= ins_v1;
        v2_q[free_idx]    <= ins_v2;
        q1_busy[free_idx] <= ins_q1_busy;
        q2_busy[free_idx] <= ins_q2_busy;
        q1_q[free_idx]    <= bus.issue_q1;
        q2_q[free_idx]    <= bus.issue_q2;
        ent_q[free_idx]   <= bus.issue_entry;
        pc_q[free_idx]    <= bus.issue_pc;
      end

      if (rdy_found) begin
        busy[rdy_idx] <= 1'b0;
        bus.execute   <= 1'b1;
        bus.op_type   <= op_q[rdy_idx];
        bus.val1      <= v1_q[rdy_idx];
        bus.val2      <= v2_q[rdy_idx];
        bus.entry     <= ent_q[rdy_idx];
        bus.nowPC     <= pc_q[rdy_idx];
      end else begin
        bus.execute   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: table-driven insert/wakeup vectors plus hand-written full, stall,
// flush and reset sequences; issued instructions are checked against a scoreboard queue.
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  reservation_station_if #(.ROB_ID_WIDTH(3), .OP_WIDTH(7), .VAL_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  reservation_station #(.RS_SIZE(8), .ROB_ID_WIDTH(3), .OP_WIDTH(7), .VAL_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  typedef struct {
    logic [6:0]  op;
    logic [31:0] v1, v2;
    logic [3:0]  ent;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] v1, v2;
    logic        q1b;
    logic [3:0]  q1;
    logic        q2b;
    logic [3:0]  q2;
    logic [3:0]  ent;
    logic [31:0] pc;
    logic        alu_en;
    int          alu_dly;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val;
    logic        lsb_en;
    int          lsb_dly;
    logic [3:0]  lsb_tag;
    logic [31:0] lsb_val;
    logic [31:0] exp_v1, exp_v2;
    int          exp_lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  vec_t cv;
  exp_t sb [$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exec_cyc = -1;
  int t0;
  int lat;
  logic rdy_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // An execute counts as a new issue only if the edge that produced it was enabled.
  always @(posedge clk) begin
    cyc++;
    rdy_prev = rdy_in;
  end

  always @(negedge clk) begin
    if (rst_in && rdy_prev && bus.execute) begin
      exec_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_execute: got entry 0x%0h expected no issue", bus.entry);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_type",  64'(bus.op_type), 64'(mon_e.op));
        chk("issue_val1",  64'(bus.val1),    64'(mon_e.v1));
        chk("issue_val2",  64'(bus.val2),    64'(mon_e.v2));
        chk("issue_entry", 64'(bus.entry),   64'(mon_e.ent));
        chk("issue_nowpc", 64'(bus.nowPC),   64'(mon_e.pc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic q1b, input logic [3:0] q1, input logic q2b, input logic [3:0] q2,
                           input logic [3:0] ent, input logic [31:0] pc);
    bus.issue_valid   = 1'b1;
    bus.issue_type    = op;
    bus.issue_v1      = v1;
    bus.issue_v2      = v2;
    bus.issue_q1_busy = q1b;
    bus.issue_q1      = q1;
    bus.issue_q2_busy = q2b;
    bus.issue_q2      = q2;
    bus.issue_entry   = ent;
    bus.issue_pc      = pc;
  endtask

  task automatic set_bc(input logic ae, input logic [3:0] at, input logic [31:0] av,
                        input logic le, input logic [3:0] lt, input logic [31:0] lv);
    bus.alu_ready = ae;
    bus.alu_entry = at;
    bus.alu_val   = av;
    bus.lsb_ready = le;
    bus.lsb_entry = lt;
    bus.lsb_val   = lv;
  endtask

  task automatic drive_bc(input vec_t v, input int k);
    set_bc(v.alu_en && v.alu_dly == k, v.alu_tag, v.alu_val,
           v.lsb_en && v.lsb_dly == k, v.lsb_tag, v.lsb_val);
  endtask

  task automatic push_exp(input logic [6:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [3:0] ent, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.ent = ent; e.pc = pc;
    sb.push_back(e);
  endtask

  initial begin
    //         op          v1             v2         q1b  q1       q2b  q2    ent    pc             alu: en dly tag      val            lsb: en dly tag      val           exp_v1         exp_v2     lat
    vecs[0] = '{7'b0100000, 32'd5,         32'd7,    1'b0, 4'd0,    1'b0, 4'd0, 4'd3,  32'h100,       1'b0, 0, 4'd0,    32'd0,         1'b0, 0, 4'd0,    32'd0,        32'd5,         32'd7,     1};
    vecs[1] = '{7'b0000010, 32'd0,         32'd1,    1'b1, 4'd2,    1'b0, 4'd0, 4'd4,  32'h104,       1'b1, 3, 4'd2,    32'h10,        1'b0, 0, 4'd0,    32'd0,        32'h10,        32'd1,     4};
    vecs[2] = '{7'b0000010, 32'd0,         32'd0,    1'b1, 4'd5,    1'b1, 4'd6, 4'd5,  32'h108,       1'b1, 0, 4'd5,    32'hA,         1'b1, 0, 4'd6,    32'hB,        32'hA,         32'hB,     1};
    vecs[3] = '{7'b0010100, 32'hFFFF,      32'd9,    1'b1, 4'd1,    1'b0, 4'd0, 4'd6,  32'h10C,       1'b1, 2, 4'd1,    32'h111,       1'b1, 2, 4'd1,    32'h222,      32'h111,       32'd9,     3};
    vecs[4] = '{7'b0110001, 32'h33,        32'd0,    1'b0, 4'd0,    1'b1, 4'd7, 4'd7,  32'h110,       1'b0, 0, 4'd0,    32'd0,         1'b1, 1, 4'd7,    32'h77,       32'h33,        32'h77,    2};
    vecs[5] = '{7'b1000110, 32'd0,         32'd0,    1'b1, 4'd4,    1'b1, 4'd4, 4'd8,  32'h114,       1'b1, 2, 4'd4,    32'h44,        1'b0, 0, 4'd0,    32'd0,        32'h44,        32'h44,    3};
    vecs[6] = '{7'b0101011, 32'd0,         32'd5,    1'b1, 4'b1010, 1'b0, 4'd0, 4'd10, 32'h118,       1'b1, 1, 4'b0010, 32'hDEAD,      1'b1, 3, 4'b1010, 32'hBEEF,     32'hBEEF,      32'd5,     4};
    vecs[7] = '{7'b0011011, 32'hFFFFFFFF,  32'd0,    1'b0, 4'd0,    1'b0, 4'd0, 4'hF,  32'hFFFFFFFC,  1'b0, 0, 4'd0,    32'd0,         1'b0, 0, 4'd0,    32'd0,        32'hFFFFFFFF,  32'd0,     1};

    bus.issue_valid = 1'b0;
    set_issue(7'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'd0);
    bus.issue_valid = 1'b0;
    set_bc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    #2 rst_in = 1'b0;
    step();
    step();
    chk("reset_execute", 64'(bus.execute), 64'd0);
    chk("reset_type",    64'(bus.op_type), 64'd0);
    chk("reset_val1",    64'(bus.val1),    64'd0);
    chk("reset_val2",    64'(bus.val2),    64'd0);
    chk("reset_entry",   64'(bus.entry),   64'd0);
    chk("reset_nowpc",   64'(bus.nowPC),   64'd0);
    chk("reset_rs_full", 64'(bus.rs_full), 64'd0);
    rst_in = 1'b1;
    step();

    // Table-driven single-instruction insert / wakeup / latency vectors.
    for (int n = 0; n < NV; n++) begin
      cv = vecs[n];
      set_issue(cv.op, cv.v1, cv.v2, cv.q1b, cv.q1, cv.q2b, cv.q2, cv.ent, cv.pc);
      drive_bc(cv, 0);
      push_exp(cv.op, cv.exp_v1, cv.exp_v2, cv.ent, cv.pc);
      exec_cyc = -1;
      step();
      t0 = cyc;
      bus.issue_valid = 1'b0;
      for (int k = 1; k <= 12 && exec_cyc < 0; k++) begin
        drive_bc(cv, k);
        step();
      end
      lat = (exec_cyc < 0) ? 999 : exec_cyc - t0;
      chk("latency", 64'(lat), 64'(cv.exp_lat));
      set_bc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      step();
      chk("exec_drop", 64'(bus.execute), 64'd0);
    end

    // Fill all slots with blocked instructions; slot i waits on tag i.
    for (int i = 0; i < 8; i++) begin
      set_issue(7'(8'h20 + i), 32'hDEAD0000, 32'(i * 3), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'h1000 + 32'(i * 4));
      step();
    end
    bus.issue_valid = 1'b0;
    chk("full_set", 64'(bus.rs_full), 64'd1);
    set_issue(7'h7F, 32'h99, 32'h98, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE, 32'h9990);
    step();
    bus.issue_valid = 1'b0;
    chk("full_drop_exec", 64'(bus.execute), 64'd0);
    chk("full_hold", 64'(bus.rs_full), 64'd1);
    set_bc(1'b1, 4'd6, 32'h600, 1'b1, 4'd1, 32'h100);
    push_exp(7'h21, 32'h100, 32'd3, 4'd1, 32'h1004);
    push_exp(7'h26, 32'h600, 32'd18, 4'd6, 32'h1018);
    step();
    set_bc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("full_after_wake", 64'(bus.rs_full), 64'd1);
    step();
    chk("order_first", 64'(bus.entry), 64'd1);
    chk("full_cleared", 64'(bus.rs_full), 64'd0);
    step();
    chk("order_second", 64'(bus.entry), 64'd6);
    chk("order_second_exec", 64'(bus.execute), 64'd1);
    step();
    chk("order_idle", 64'(bus.execute), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(bus.rs_full), 64'd0);

    // Stall with a ready slot pending, then flush with rdy_in high.
    set_issue(7'h05, 32'h0, 32'hC2, 1'b1, 4'd5, 1'b0, 4'd0, 4'd12, 32'h2000);
    step();
    set_issue(7'h11, 32'hA1, 32'hA2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13, 32'h2004);
    push_exp(7'h11, 32'hA1, 32'hA2, 4'd13, 32'h2004);
    step();
    set_issue(7'h12, 32'hB1, 32'hB2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14, 32'h2008);
    step();
    bus.issue_valid = 1'b0;
    rdy_in = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("stall_execute", 64'(bus.execute), 64'd1);
      chk("stall_entry",   64'(bus.entry),   64'd13);
    end
    rdy_in = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_execute", 64'(bus.execute), 64'd0);
    chk("flush_rs_full", 64'(bus.rs_full), 64'd0);
    for (int s = 0; s < 3; s++) begin
      set_bc(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0);
      step();
      chk("flush_no_issue", 64'(bus.execute), 64'd0);
    end
    set_bc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    // Reset in the middle of operation with three blocked slots and execute high.
    for (int i = 1; i <= 3; i++) begin
      set_issue(7'h30, 32'h0, 32'h0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'h3000);
      step();
    end
    set_issue(7'h0D, 32'h0D, 32'hD0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h3010);
    push_exp(7'h0D, 32'h0D, 32'hD0, 4'd9, 32'h3010);
    step();
    bus.issue_valid = 1'b0;
    step();
    chk("pre_reset_execute", 64'(bus.execute), 64'd1);
    rst_in = 1'b0;
    #1;
    chk("midreset_execute", 64'(bus.execute), 64'd0);
    chk("midreset_val1",    64'(bus.val1),    64'd0);
    chk("midreset_entry",   64'(bus.entry),   64'd0);
    chk("midreset_rs_full", 64'(bus.rs_full), 64'd0);
    #1;
    rst_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_bc(1'b1, 4'(i), 32'h700 + 32'(i), 1'b1, 4'(i), 32'h800 + 32'(i));
      step();
      chk("postreset_no_issue", 64'(bus.execute), 64'd0);
    end
    set_bc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    set_issue(7'h41, 32'h1234, 32'h5678, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h4000);
    push_exp(7'h41, 32'h1234, 32'h5678, 4'd2, 32'h4000);
    step();
    bus.issue_valid = 1'b0;
    step();
    chk("postreset_issue", 64'(bus.execute), 64'd1);
    step();
    chk("postreset_drop", 64'(bus.execute), 64'd0);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
